mips_muldiv: RTL
================

# mips_muldiv

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core, generalised over datapath width. It sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decode/execute control. It holds `busy` so the hazard logic can stall MFHI/MFLO and further mul/div issue. It produces signed or unsigned results in a fixed, width-dependent number of cycles.

## Interface
- `WIDTH`, 32, operand and HI/LO width; even, ≥ 4.
- `clk`  in  1  clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue request, sampled on a rising edge; accepted only when `busy`=0.
- `flush`  in  1  abort in-flight operation (pipeline exception/branch squash).
- `op`  in  3  0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6–7 no-op.
- `rs_val`  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- `rt_val`  in  WIDTH  multiplier / divisor.
- `busy`  out  1  operation in flight; reset 0.
- `done`  out  1  one-cycle pulse, HI/LO just updated by mul/div; reset 0.
- `div_zero`  out  1  valid with `done`: last divide had divisor 0; reset 0.
- `hi`  out  WIDTH  HI register; reset 0.
- `lo`  out  WIDTH  LO register; reset 0.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + `start` + op 0–3: latch operand magnitudes. For signed ops, negate negative operands; unsigned ops take them as-is. Record result signs, clear the iteration counter, go to MUL or DIV, raise `busy`.
- IDLE + `start` + op 4/5: write `hi`/`lo` = `rs_val` at that edge. No `busy`, no `done`.
- IDLE + `start` + op 6/7: ignored.
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator, WIDTH iterations, then FIX.
- DIV: restoring division, one quotient bit per cycle, WIDTH iterations, then FIX.
- FIX: apply signs and write HI/LO. Return to IDLE, drop `busy`, pulse `done`.
  - MULT: product negated (2·WIDTH wide) if operand signs differ. `hi` = upper WIDTH bits, `lo` = lower WIDTH bits.
  - DIV: `lo` = quotient, negated if signs differ. `hi` = remainder, carrying the dividend's sign.
  - Divisor 0 (DIV or DIVU): `lo` = all-ones, `hi` = original `rs_val`, `div_zero`=1, regardless of signs.
  - Signed MIN/−1: `lo` = MIN, `hi` = 0, no flag.
- `start` while `busy`: ignored entirely, including MTHI/MTLO. The hazard unit must stall.
- `flush` in MUL/DIV/FIX: next state IDLE, `hi`/`lo` unchanged, no `done`. `flush` beats `start` in the same cycle. `flush` in IDLE: no effect.
- Reset (any time, including mid-operation): IDLE, all outputs 0, counter 0.

## Timing
- Start edge E0. Iterations occur on E1…E_WIDTH. FIX writes on E_(WIDTH+1).
- `busy` is high from E0 to E_(WIDTH+1): WIDTH+1 cycles, 33 for WIDTH=32.
- `done` and the new `hi`/`lo` are visible in the cycle after E_(WIDTH+1). `div_zero` is held until the next accepted mul/div start.
- A back-to-back start is legal in the `done` cycle, giving a throughput of one op per WIDTH+2 cycles.
- MTHI/MTLO: value visible in the cycle after the start edge.
- Counter width is $clog2(WIDTH+1). Internal intermediates are 2·WIDTH bits; divide uses a WIDTH+1-bit partial remainder.

## Structure
- `mips_pkg`: `muldiv_op_t` encodings (MULTU…MTLO), state enum.
- One natural sub-module, `muldiv_step`: combinational single iteration. It does shift-add for multiply and compare-subtract for divide, parametrised by WIDTH.
- HI/LO registers, FSM, counter and sign fix-up live in `mips_muldiv`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 busy cycles `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` pulses once.
- MULT −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 7 / 0 → `lo`=0xFFFFFFFF, `hi`=0x00000007, `div_zero`=1. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_zero`=0.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → `hi`=0x1234, `lo`=0x5678, `busy` stays 0. MTHI issued while busy → `hi` unchanged.
- `flush` on the 10th busy cycle of MULT 5×5 → `busy`=0 next cycle, `hi`/`lo` keep prior values, no `done`. Same-cycle `start`+`flush` in IDLE → not accepted.
- Reset asserted mid-DIV → `busy`, `done`, `div_zero`, `hi`, `lo` all 0 immediately. WIDTH=8 instance: DIVU 200/7 → `lo`=28, `hi`=4 after 9 busy cycles.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the iterative MIPS multiply/divide unit.
package mips_muldiv_pkg;

    typedef enum logic [2:0] {
        OpMultu = 3'd0,
        OpMult  = 3'd1,
        OpDivu  = 3'd2,
        OpDiv   = 3'd3,
        OpMthi  = 3'd4,
        OpMtlo  = 3'd5,
        OpNop6  = 3'd6,
        OpNop7  = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StFix  = 2'd3
    } muldiv_state_t;

    function automatic logic op_is_signed(muldiv_op_t op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

    function automatic logic op_is_div(muldiv_op_t op);
        return (op == OpDivu) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One combinational iteration: shift-add multiply step and restoring divide step.
module mips_muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   rem_i,
    input  logic [WIDTH-1:0]   quot_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0]   rem_o,
    output logic [WIDTH-1:0]   quot_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           ge;

    // Multiplier sits in the low half and is consumed LSB-first as the product shifts in.
    assign sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, mcand_i};
    assign acc_o = acc_i[0] ? {sum, acc_i[WIDTH-1:1]} : {1'b0, acc_i[2*WIDTH-1:1]};

    // Dividend bits leave the top of the quotient register as quotient bits enter at the bottom.
    assign shifted = {rem_i, quot_i[WIDTH-1]};
    assign ge      = shifted >= {1'b0, divisor_i};
    assign rem_o   = ge ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];
    assign quot_o  = {quot_i[WIDTH-2:0], ge};

endmodule

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO for the MIPS EX stage.
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] rs_val_i,
    input  logic [WIDTH-1:0] rt_val_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    muldiv_state_t      state_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   rs_orig_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               is_div_q;
    logic               dz_q;
    logic               done_q;
    logic               div_zero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    muldiv_op_t         op;
    logic               sgn;
    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quot_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign op     = muldiv_op_t'(op_i);
    assign sgn    = op_is_signed(op);
    assign rs_neg = sgn & rs_val_i[WIDTH-1];
    assign rt_neg = sgn & rt_val_i[WIDTH-1];
    assign rs_mag = rs_neg ? (WIDTH'(0) - rs_val_i) : rs_val_i;
    assign rt_mag = rt_neg ? (WIDTH'(0) - rt_val_i) : rt_val_i;

    mips_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i     (acc_q),
        .mcand_i   (opb_q),
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (opb_q),
        .acc_o     (acc_d),
        .rem_o     (rem_d),
        .quot_o    (quot_d)
    );

    // Signed MIN / -1 needs no special case: the magnitude path wraps to MIN with remainder 0.
    assign prod_fix = neg_res_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
    assign quot_fix = neg_res_q ? (WIDTH'(0) - quot_q) : quot_q;
    assign rem_fix  = neg_rem_q ? (WIDTH'(0) - rem_q) : rem_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            opb_q      <= '0;
            rs_orig_q  <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i && !flush_i) begin
                        case (op)
                            OpMultu, OpMult, OpDivu, OpDiv: begin
                                cnt_q      <= '0;
                                neg_res_q  <= rs_neg ^ rt_neg;
                                neg_rem_q  <= rs_neg;
                                rs_orig_q  <= rs_val_i;
                                is_div_q   <= op_is_div(op);
                                div_zero_q <= 1'b0;
                                if (op_is_div(op)) begin
                                    state_q <= StDiv;
                                    quot_q  <= rs_mag;
                                    rem_q   <= '0;
                                    opb_q   <= rt_mag;
                                    dz_q    <= (rt_val_i == '0);
                                end else begin
                                    state_q <= StMul;
                                    acc_q   <= {{WIDTH{1'b0}}, rt_mag};
                                    opb_q   <= rs_mag;
                                    dz_q    <= 1'b0;
                                end
                            end
                            OpMthi:  hi_q <= rs_val_i;
                            OpMtlo:  lo_q <= rs_val_i;
                            default: ;
                        endcase
                    end
                end
                StMul, StDiv: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        if (state_q == StMul) begin
                            acc_q <= acc_d;
                        end else begin
                            rem_q  <= rem_d;
                            quot_q <= quot_d;
                        end
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == LastIter) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    state_q <= StIdle;
                    if (!flush_i) begin
                        done_q     <= 1'b1;
                        div_zero_q <= is_div_q & dz_q;
                        if (!is_div_q) begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end else if (dz_q) begin
                            hi_q <= rs_orig_q;
                            lo_q <= {WIDTH{1'b1}};
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule
